// File: rtl/edge_evt_pkg.sv
// Shared types for the edge event scheduler.
package edge_evt_pkg;

  // Output port state: IDLE picks the next pending channel, OFFER holds it until accepted.
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_t;

endpackage

// File: rtl/edge_evt_chan.sv
// One scheduler channel: 2-flop synchroniser, dual-edge detect, single-entry pending slot
// with polarity and a sticky overflow flag.
module edge_evt_chan (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  input  logic load_i,
  input  logic clr_ovf_i,
  output logic pending_o,
  output logic pol_o,
  output logic overflow_o
);

  logic sync1_q, sync2_q, prev_q;
  logic pending_q, pending_d;
  logic pol_q, pol_d;
  logic ovf_q, ovf_d;
  logic edge_det;
  logic ovf_set;

  assign edge_det = sync2_q ^ prev_q;

  // Next pending/polarity/overflow; a load in the same cycle as a new edge hands the old
  // event out and keeps the new one pending, so nothing is lost.
  always_comb begin
    pending_d = pending_q;
    pol_d     = pol_q;
    ovf_set   = 1'b0;
    if (edge_det) begin
      pending_d = 1'b1;
      pol_d     = sync2_q;
      ovf_set   = pending_q & ~load_i;
    end else if (load_i) begin
      pending_d = 1'b0;
    end
    // Setting wins over a simultaneous clear.
    ovf_d = (ovf_q & ~clr_ovf_i) | ovf_set;
  end

  // Synchroniser, edge history and pending state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      pol_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= level_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      pol_q     <= pol_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o  = pending_q;
  assign pol_o      = pol_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// Multi-channel dual-edge event scheduler: per-channel edge capture plus a round-robin
// arbiter feeding a single registered valid/ready event port.
module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   level,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rise,
  output logic [N-1:0]   overflow,
  input  logic [N-1:0]   clr_overflow
);

  logic [N-1:0]   pending;
  logic [N-1:0]   pol;
  logic [N-1:0]   load_vec;
  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;

  sched_state_t   state_q, state_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic           rise_q, rise_d;
  logic [IDW-1:0] rr_q, rr_d;

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_evt_chan u_chan (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .level_i    (level[i]),
      .load_i     (load_vec[i]),
      .clr_ovf_i  (clr_overflow[i]),
      .pending_o  (pending[i]),
      .pol_o      (pol[i]),
      .overflow_o (overflow[i])
    );
  end

  // Round-robin pick: first pending channel searching upward from rr+1, wrapping at N.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(rr_q) + k) % N);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    load_vec = '0;
    if (state_q == IDLE && found) begin
      load_vec[sel] = 1'b1;
    end
  end

  // FSM next state and registered output port contents.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    rise_d  = rise_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = sel;
          rise_d  = pol[sel];
          valid_d = 1'b1;
          rr_d    = sel;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      rise_q  <= 1'b0;
      rr_q    <= IDW'(N - 1);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      rise_q  <= rise_d;
      rr_q    <= rr_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign evt_rise  = rise_q;

endmodule
